wave_synth_multi: RTL

WAVE_SYNTH_MULTI -- requirements
Module: wave_synth_multi

---
 rtl/wave_synth_multi.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wave_synth_multi.sv
// -----------------------------------------------------------------------------
// wave_synth_multi
//
// Multi-voice wavetable-free oscillator bank with a PWM audio back end.
// Each voice owns a phase accumulator advanced once per PWM period (at the
// wrap of the free-running PWM counter).  Every voice turns its phase into
// a PWM_W-bit value (square / saw / optional triangle).  The values are
// summed and scaled into one mixed sample, which becomes the PWM duty for
// the following period.
//
// Optional feature macro:
//   WAVE_SYNTH_TRIANGLE_EN  - when defined, mode 2'b10 is a triangle wave;
//                             when undefined, mode 2'b10 behaves as square.
//
// Parameters:
//   NUM_VOICES - number of voices (power of two, 1..16)
//   PHASE_W    - phase accumulator / frequency control word width
//   PWM_W      - PWM counter, sample and duty width (PHASE_W >= PWM_W+1)
//
// Ports:
//   clk           - sole clock
//   rst           - asynchronous, active-high reset
//   cfg_valid     - configuration write request
//   cfg_ready     - configuration write accept (low during the wrap cycle)
//   cfg_voice     - target voice index (out-of-range index is a no-op)
//   cfg_fcw       - frequency control word for the voice
//   cfg_mode      - 00 square, 01 saw, 10 triangle, 11 reserved (silent)
//   cfg_en        - voice enable
//   cfg_phase_rst - clear the voice phase as part of the write
//   sample_out    - latest mixed sample
//   sample_valid  - one-cycle strobe whenever sample_out updates
//   aud_pwm       - PWM audio output
//   aud_sd        - amplifier enable (any voice enabled)
// -----------------------------------------------------------------------------
module wave_synth_multi #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int PWM_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(NUM_VOICES):0]   cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_fcw,
    input  logic [1:0]                    cfg_mode,
    input  logic                          cfg_en,
    input  logic                          cfg_phase_rst,
    output logic [PWM_W-1:0]              sample_out,
    output logic                          sample_valid,
    output logic                          aud_pwm,
    output logic                          aud_sd
);

    localparam int VIDX_W  = $clog2(NUM_VOICES) + 1;
    localparam int LOG2_NV = $clog2(NUM_VOICES);
    localparam int SUM_W   = PWM_W + LOG2_NV;

    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};
    // Counter value one cycle before the wrap; cfg_ready is pre-computed
    // from it so that the ready output can be a plain register.
    localparam logic [PWM_W-1:0] CNT_PRE = CNT_MAX - PWM_W'(1'b1);

    logic [PWM_W-1:0]   pwm_cnt_r;
    logic [PWM_W-1:0]   duty_r;
    logic [PWM_W-1:0]   sample_r;
    logic               sample_valid_r;
    logic               aud_pwm_r;
    logic               aud_sd_r;
    logic               cfg_ready_r;

    logic [PHASE_W-1:0] phase_r [NUM_VOICES];
    logic [PHASE_W-1:0] fcw_r   [NUM_VOICES];
    logic [1:0]         mode_r  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_r;

    logic [PWM_W-1:0]   voice_val_s [NUM_VOICES];
    logic [SUM_W-1:0]   sum_s;
    logic [PWM_W-1:0]   mix_s;
    logic               wrap_s;
    logic               cfg_we_s;
    logic               voice_ok_s;

    assign wrap_s     = (pwm_cnt_r == CNT_MAX);
    // cfg_ready_r is low exactly in the wrap cycle, so a write never lands
    // on the same edge as a phase advance.
    assign cfg_we_s   = cfg_valid && cfg_ready_r;
    assign voice_ok_s = (cfg_voice < VIDX_W'(NUM_VOICES));

    // Per-voice waveform value derived from the current phase.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_val_s[v] = {PWM_W{1'b0}};
            if (en_r[v]) begin
                case (mode_r[v])
                    2'b00: voice_val_s[v] = phase_r[v][PHASE_W-1] ? {PWM_W{1'b0}} : {PWM_W{1'b1}};
                    2'b01: voice_val_s[v] = phase_r[v][PHASE_W-1 -: PWM_W];
`ifdef WAVE_SYNTH_TRIANGLE_EN
                    // Rising half uses the bits below the MSB; falling half mirrors them.
                    2'b10: voice_val_s[v] = phase_r[v][PHASE_W-1] ? ~phase_r[v][PHASE_W-2 -: PWM_W]
                                                                  :  phase_r[v][PHASE_W-2 -: PWM_W];
`else
                    2'b10: voice_val_s[v] = phase_r[v][PHASE_W-1] ? {PWM_W{1'b0}} : {PWM_W{1'b1}};
`endif
                    default: voice_val_s[v] = {PWM_W{1'b0}};
                endcase
            end else begin
                voice_val_s[v] = {PWM_W{1'b0}};
            end
        end
    end

    // Unsaturated mix: sum all voices, then divide by the voice count.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum_s = sum_s + SUM_W'(voice_val_s[v]);
        end
        mix_s = PWM_W'(sum_s >> LOG2_NV);
    end

    // PWM counter, duty/sample latch at wrap, and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r      <= {PWM_W{1'b0}};
            duty_r         <= {PWM_W{1'b0}};
            sample_r       <= {PWM_W{1'b0}};
            sample_valid_r <= 1'b0;
            aud_pwm_r      <= 1'b0;
            aud_sd_r       <= 1'b0;
            cfg_ready_r    <= 1'b1;
        end else begin
            pwm_cnt_r      <= pwm_cnt_r + PWM_W'(1'b1);
            aud_pwm_r      <= (pwm_cnt_r < duty_r);
            aud_sd_r       <= |en_r;
            cfg_ready_r    <= (pwm_cnt_r != CNT_PRE);
            sample_valid_r <= wrap_s;
            if (wrap_s) begin
                duty_r   <= mix_s;
                sample_r <= mix_s;
            end
        end
    end

    // Per-voice configuration writes and phase accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r <= {NUM_VOICES{1'b0}};
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_r[v] <= {PHASE_W{1'b0}};
                fcw_r[v]   <= {PHASE_W{1'b0}};
                mode_r[v]  <= 2'b00;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wrap_s && en_r[v]) begin
                    phase_r[v] <= phase_r[v] + fcw_r[v];
                end else if (cfg_we_s && voice_ok_s && (cfg_voice == VIDX_W'(v)) && cfg_phase_rst) begin
                    phase_r[v] <= {PHASE_W{1'b0}};
                end
                if (cfg_we_s && voice_ok_s && (cfg_voice == VIDX_W'(v))) begin
                    fcw_r[v]  <= cfg_fcw;
                    mode_r[v] <= cfg_mode;
                    en_r[v]   <= cfg_en;
                end
            end
        end
    end

    assign cfg_ready    = cfg_ready_r;
    assign sample_out   = sample_r;
    assign sample_valid = sample_valid_r;
    assign aud_pwm      = aud_pwm_r;
    assign aud_sd       = aud_sd_r;

endmodule
